// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gate_bist_pkg;

    localparam int VEC_W    = 2;
    localparam int LOOP_W   = 6;
    localparam int SETTLE_W = 4;

    localparam logic [3:0] EXP_NOR = 4'b0001;
    localparam logic [3:0] EXP_AND = 4'b1000;
    localparam logic [3:0] EXP_OR  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CHECK,
        ST_FINISH
    } state_t;

    // Expected gate output for input vector {a,b}.
    function automatic logic exp_bit(input logic [3:0] tbl, input logic [VEC_W-1:0] vec);
        return tbl[vec];
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Control/observation bundle between the BIST sequencer, its requester and the gate under test.
// Latency: none (wiring only).
// Backpressure: none; start/done handshake, GATE_BIST_FAILLOG_EN adds the fail-log signals.
interface gate_bist_ctrl_if;
    import gate_bist_pkg::*;

    logic             start;
    logic             abort;
    logic             gate_y;
    logic             gate_a;
    logic             gate_b;
    logic             busy;
    logic             done;
    logic             pass;
`ifdef GATE_BIST_FAILLOG_EN
    logic [7:0]       err_cnt;
    logic [VEC_W-1:0] first_fail;
    logic             fail_valid;
`endif

    // Requester side: issues start/abort and closes the loop through the gate.
    modport master (
        output start, abort, gate_y,
        input  gate_a, gate_b, busy, done, pass
`ifdef GATE_BIST_FAILLOG_EN
        , input err_cnt, first_fail, fail_valid
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, abort, gate_y,
        output gate_a, gate_b, busy, done, pass
`ifdef GATE_BIST_FAILLOG_EN
        , output err_cnt, first_fail, fail_valid
`endif
    );

endinterface

// File: rtl/gate_bist_seq_cnt.sv
// Vector/loop counter: walks {a,b} through 00..11 for N_LOOPS sweeps, flags the final vector.
// Latency: vector updates one edge after load/advance; last is combinational from state.
// Backpressure: none; load has priority over advance.
module gate_bist_seq_cnt
    import gate_bist_pkg::*;
#(
    parameter int N_LOOPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             last_o
);

    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [LOOP_W-1:0] loop_q, loop_d;

    // Next vector/loop: load clears both, advance steps the vector and bumps loop on wrap.
    always_comb begin
        vec_d  = vec_q;
        loop_d = loop_q;
        if (load_i) begin
            vec_d  = '0;
            loop_d = '0;
        end else if (adv_i) begin
            vec_d = vec_q + VEC_W'(1);
            if (vec_q == '1) begin
                loop_d = loop_q + LOOP_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            loop_q <= '0;
        end else begin
            vec_q  <= vec_d;
            loop_q <= loop_d;
        end
    end

    assign vec_o  = vec_q;
    assign last_o = (vec_q == '1) && (loop_q == LOOP_W'(N_LOOPS - 1));

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for one 2-input gate: sweeps all vectors, compares against EXP_TABLE, reports pass.
// Latency: done 1 + 4*N_LOOPS*(SETTLE_CYCLES+1) cycles after start acceptance.
// Backpressure: start only taken in IDLE; abort cancels a run; GATE_BIST_FAILLOG_EN adds err/first-fail log.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] EXP_TABLE     = EXP_NOR,
    parameter int         N_LOOPS       = 1,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gate_bist_ctrl_if.slave bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                fail_q, fail_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;
    logic                cnt_load;
    logic                cnt_adv;
    logic                vec_last;
    logic [VEC_W-1:0]    vec;
    logic                mismatch;

`ifdef GATE_BIST_FAILLOG_EN
    logic [7:0]          err_q, err_d;
    logic [VEC_W-1:0]    ff_q, ff_d;
    logic                fv_q, fv_d;
`endif

    // The counter register doubles as the registered gate input drive.
    gate_bist_seq_cnt #(
        .N_LOOPS (N_LOOPS)
    ) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .adv_i   (cnt_adv),
        .vec_o   (vec),
        .last_o  (vec_last)
    );

    assign mismatch = (bus.gate_y != exp_bit(EXP_TABLE, vec));

    // FSM next state, counter control, compare and result bookkeeping.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
`ifdef GATE_BIST_FAILLOG_EN
        err_d    = err_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_APPLY;
                    settle_d = SETTLE_LD;
                    cnt_load = 1'b1;
                    fail_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef GATE_BIST_FAILLOG_EN
                    err_d    = '0;
                    ff_d     = '0;
                    fv_d     = 1'b0;
`endif
                end
            end
            ST_APPLY: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    cnt_load = 1'b1;
                end else if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_CHECK: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    cnt_load = 1'b1;
                end else begin
                    if (mismatch) begin
                        fail_d = 1'b1;
`ifdef GATE_BIST_FAILLOG_EN
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (!fv_q) begin
                            ff_d = vec;
                            fv_d = 1'b1;
                        end
`endif
                    end
                    if (vec_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d  = ST_APPLY;
                        settle_d = SETTLE_LD;
                        cnt_adv  = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                // Result and done leave on the same edge that returns to IDLE.
                state_d = ST_IDLE;
                done_d  = 1'b1;
                pass_d  = ~fail_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            fail_q   <= 1'b0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

`ifdef GATE_BIST_FAILLOG_EN
    // Fail-log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            ff_q  <= '0;
            fv_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            ff_q  <= ff_d;
            fv_q  <= fv_d;
        end
    end

    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_valid = fv_q;
`endif

    assign bus.gate_a = vec[1];
    assign bus.gate_b = vec[0];
    assign bus.busy   = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign bus.done   = done_q;
    assign bus.pass   = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench: three sequencer instances (default, 3 loops/2 settle, mis-programmed table).
// Latency: each run is timed from the start-accept edge to the done pulse.
// Backpressure: start held during a run, abort mid-run and async reset mid-run are exercised.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       stuck0  = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] abort_v = '0;

    gate_bist_ctrl_if bus0 ();
    gate_bist_ctrl_if bus1 ();
    gate_bist_ctrl_if bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.abort = abort_v[0];
    assign bus1.abort = abort_v[1];
    assign bus2.abort = abort_v[2];

    // Gate models: a NOR cell, with the first one optionally stuck at 0.
    assign bus0.gate_y = stuck0 ? 1'b0 : ~(bus0.gate_a | bus0.gate_b);
    assign bus1.gate_y = ~(bus1.gate_a | bus1.gate_b);
    assign bus2.gate_y = ~(bus2.gate_a | bus2.gate_b);

    gate_bist_ctrl #(.EXP_TABLE(EXP_NOR), .N_LOOPS(1), .SETTLE_CYCLES(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    gate_bist_ctrl #(.EXP_TABLE(EXP_NOR), .N_LOOPS(3), .SETTLE_CYCLES(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    gate_bist_ctrl #(.EXP_TABLE(4'b0111), .N_LOOPS(1), .SETTLE_CYCLES(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    logic [2:0] done_w, busy_w, pass_w;
    logic [1:0] vec_w [3];
    assign done_w   = {bus2.done, bus1.done, bus0.done};
    assign busy_w   = {bus2.busy, bus1.busy, bus0.busy};
    assign pass_w   = {bus2.pass, bus1.pass, bus0.pass};
    assign vec_w[0] = {bus0.gate_a, bus0.gate_b};
    assign vec_w[1] = {bus1.gate_a, bus1.gate_b};
    assign vec_w[2] = {bus2.gate_a, bus2.gate_b};
`ifdef GATE_BIST_FAILLOG_EN
    logic [7:0] err_w [3];
    logic [1:0] ff_w  [3];
    logic [2:0] fv_w;
    assign err_w[0] = bus0.err_cnt;
    assign err_w[1] = bus1.err_cnt;
    assign err_w[2] = bus2.err_cnt;
    assign ff_w[0]  = bus0.first_fail;
    assign ff_w[1]  = bus1.first_fail;
    assign ff_w[2]  = bus2.first_fail;
    assign fv_w     = {bus2.fail_valid, bus1.fail_valid, bus0.fail_valid};
`endif

    typedef struct {
        int dut;
        bit stuck;
        int lat;
        bit pass;
        int err;
        int ff;
        bit fv;
    } rec_t;

    rec_t tbl [5];
    rec_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse start for one edge; k becomes the accepting edge number.
    task automatic do_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int d, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_w[d]) begin
                lat = cyc - k;
                break;
            end
        end
    endtask

    task automatic run_rec(input rec_t r);
        rec_t e;
        int   lat;
        stuck0 = r.stuck;
        sb.push_back(r);
        do_start(r.dut);
        wait_done(r.dut, 60, lat);
        e = sb.pop_front();
        check("done_latency", lat, e.lat);
        check("pass_at_done", pass_w[e.dut], e.pass);
`ifdef GATE_BIST_FAILLOG_EN
        check("err_cnt", err_w[e.dut], e.err);
        check("first_fail", ff_w[e.dut], e.ff);
        check("fail_valid", fv_w[e.dut], e.fv);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done_w[e.dut], 0);
        check("pass_held", pass_w[e.dut], e.pass);
        stuck0 = 1'b0;
    endtask

    initial begin
        int ndone;
        int lat;

        // dut, stuck, latency, pass, err_cnt, first_fail, fail_valid
        tbl[0] = '{0, 1'b0,  9, 1'b1, 0, 0, 1'b0};
        // Stuck-0 output only disagrees with NOR at vector 00.
        tbl[1] = '{0, 1'b1,  9, 1'b0, 1, 0, 1'b1};
        // Good run after a failing one: log must be cleared.
        tbl[2] = '{0, 1'b0,  9, 1'b1, 0, 0, 1'b0};
        // 1 + 4*3*(2+1) = 37.
        tbl[3] = '{1, 1'b0, 37, 1'b1, 0, 0, 1'b0};
        // NOR gives y=1,0,0,0 for 00..11; table 0111 disagrees at 01 and 10.
        tbl[4] = '{2, 1'b0,  9, 1'b0, 2, 1, 1'b1};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_pass", pass_w[0], 0);
        check("rst_vec", vec_w[0], 0);
`ifdef GATE_BIST_FAILLOG_EN
        check("rst_err_cnt", err_w[0], 0);
        check("rst_first_fail", ff_w[0], 0);
        check("rst_fail_valid", fv_w[0], 0);
`endif

        // Vector stepping: 00,01,10,11 with two cycles each, then FINISH, then done.
        do_start(0);
        for (int i = 0; i < 8; i++) begin
            check("vec_step", vec_w[0], i / 2);
            check("busy_in_run", busy_w[0], 1);
            @(posedge clk); #1;
        end
        check("finish_not_busy", busy_w[0], 0);
        check("finish_no_done_yet", done_w[0], 0);
        @(posedge clk); #1;
        check("step_done_at_9", done_w[0], 1);
        check("step_pass", pass_w[0], 1);
        @(posedge clk); #1;

        foreach (tbl[i]) run_rec(tbl[i]);

        // Start held high through most of the run: no restart, one done at k+9.
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        repeat (5) begin
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_w[0]) begin
                ndone++;
                lat = cyc - k;
            end
        end
        check("held_start_done_count", ndone, 1);
        check("held_start_latency", lat, 9);
        check("held_start_idle", busy_w[0], 0);

        // Abort while vector 10 is applied.
        do_start(0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_vec_before", vec_w[0], 2);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check("abort_busy", busy_w[0], 0);
        check("abort_vec", vec_w[0], 0);
        check("abort_pass", pass_w[0], 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_w[0]) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_pass_later", pass_w[0], 0);

        // Asynchronous reset in the middle of APPLY (vector 01), between clock edges.
        do_start(0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("prerst_busy", busy_w[0], 1);
        check("prerst_vec", vec_w[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy_w[0], 0);
        check("async_rst_vec", vec_w[0], 0);
        check("async_rst_done", done_w[0], 0);
        check("async_rst_pass", pass_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", busy_w[0], 0);
        run_rec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
